// File: rtl/rename_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rename_unit                                                |
// | Description : Multi-lane register renaming with a speculative map and    |
// |               free bitmap plus a retirement copy for flush recovery.     |
// |               Optional same-group source bypass: RENAME_BYPASS_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rename_unit #(
  parameter int ARCH_REGS    = 32,
  parameter int PHYS_REGS    = 64,
  parameter int RENAME_WIDTH = 2,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int N  = RENAME_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    ren_valid_i,
  output logic            ren_ready_o,
  input  logic [N*AW-1:0] ren_src1_i,
  input  logic [N*AW-1:0] ren_src2_i,
  input  logic [N*AW-1:0] ren_dst_i,
  input  logic [N-1:0]    ren_dst_wr_i,
  output logic [N*PW-1:0] ren_psrc1_o,
  output logic [N*PW-1:0] ren_psrc2_o,
  output logic [N*PW-1:0] ren_pdst_o,
  output logic [N*PW-1:0] ren_pold_o,
  input  logic [N-1:0]    cmt_valid_i,
  input  logic [N*AW-1:0] cmt_dst_i,
  input  logic [N*PW-1:0] cmt_pdst_i,
  input  logic [N*PW-1:0] cmt_pold_i,
  input  logic            flush_i,
  output logic [PW:0]     free_count_o
);

  function automatic logic [ARCH_REGS-1:0][PW-1:0] f_identity_map();
    logic [ARCH_REGS-1:0][PW-1:0] m;
    for (int a = 0; a < ARCH_REGS; a++) m[a] = PW'(a);
    return m;
  endfunction

  localparam logic [ARCH_REGS-1:0][PW-1:0] MAP_RST  = f_identity_map();
  localparam logic [PHYS_REGS-1:0]         FREE_RST = {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [ARCH_REGS-1:0][PW-1:0] spec_map_q, spec_map_d, ret_map_q, ret_map_d;
  logic [PHYS_REGS-1:0]         spec_free_q, spec_free_d, ret_free_q, ret_free_d;
  logic [PW:0]                  free_cnt_q, free_cnt_d;

  // Flat lane buses viewed as per-lane arrays (same bit layout).
  logic [N-1:0][AW-1:0] src1, src2, dst, cdst;
  logic [N-1:0][PW-1:0] psrc1, psrc2, pdst, pold, cpdst, cpold;
  logic [N-1:0]         alloc;
  logic [PHYS_REGS-1:0] avail;
  logic                 fire;
  logic                 double_free;
`ifndef RENAME_BYPASS_EN
  logic                 group_dep;
`endif

  assign src1  = ren_src1_i;
  assign src2  = ren_src2_i;
  assign dst   = ren_dst_i;
  assign cdst  = cmt_dst_i;
  assign cpdst = cmt_pdst_i;
  assign cpold = cmt_pold_i;

  assign ren_psrc1_o  = psrc1;
  assign ren_psrc2_o  = psrc2;
  assign ren_pdst_o   = pdst;
  assign ren_pold_o   = pold;
  assign free_count_o = free_cnt_q;

  // Readiness only looks at the registered count so a full group always fits.
  assign ren_ready_o = (free_cnt_q >= (PW+1)'(N));
  assign fire        = ren_ready_o & (|ren_valid_i) & ~flush_i;

  // Allocation: lanes in ascending order each take the lowest remaining free reg.
  always_comb begin
    avail = spec_free_q;
    alloc = '0;
    pdst  = '0;
    for (int i = 0; i < N; i++) begin
      alloc[i] = ren_valid_i[i] & ren_dst_wr_i[i] & (dst[i] != '0);
      if (alloc[i]) begin
        for (int p = PHYS_REGS-1; p > 0; p--) begin
          if (avail[p]) pdst[i] = PW'(p);
        end
        avail[pdst[i]] = 1'b0;
      end
    end
  end

  // Lookups against the pre-group map, corrected by earlier lanes of the same group.
  always_comb begin
    psrc1 = '0;
    psrc2 = '0;
    pold  = '0;
`ifndef RENAME_BYPASS_EN
    group_dep = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      psrc1[i] = (src1[i] == '0) ? '0 : spec_map_q[src1[i]];
      psrc2[i] = (src2[i] == '0) ? '0 : spec_map_q[src2[i]];
      if (alloc[i]) pold[i] = spec_map_q[dst[i]];
      // Ascending scan: the nearest earlier lane overwrites last and wins.
      for (int j = 0; j < i; j++) begin
        if (alloc[j]) begin
          if (alloc[i] && (dst[j] == dst[i])) pold[i] = pdst[j];
`ifdef RENAME_BYPASS_EN
          if (src1[i] == dst[j]) psrc1[i] = pdst[j];
          if (src2[i] == dst[j]) psrc2[i] = pdst[j];
`else
          if (ren_valid_i[i] && ((src1[i] == dst[j]) || (src2[i] == dst[j])))
            group_dep = 1'b1;
`endif
        end
      end
    end
  end

  // Next state: rename updates, then commits, then flush restores from retire copy.
  always_comb begin
    spec_map_d  = spec_map_q;
    spec_free_d = spec_free_q;
    ret_map_d   = ret_map_q;
    ret_free_d  = ret_free_q;
    double_free = 1'b0;
    if (fire) begin
      for (int i = 0; i < N; i++) begin
        if (alloc[i]) begin
          spec_map_d[dst[i]]   = pdst[i];
          spec_free_d[pdst[i]] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cmt_valid_i[i] && (cdst[i] != '0)) begin
        ret_map_d[cdst[i]]   = cpdst[i];
        ret_free_d[cpdst[i]] = 1'b0;
        if (cpold[i] != '0) begin
          if (spec_free_q[cpold[i]]) double_free = 1'b1;
          ret_free_d[cpold[i]]  = 1'b1;
          spec_free_d[cpold[i]] = 1'b1;
        end
      end
    end
    if (flush_i) begin
      spec_map_d  = ret_map_d;
      spec_free_d = ret_free_d;
    end
    free_cnt_d = '0;
    for (int p = 0; p < PHYS_REGS; p++) free_cnt_d = free_cnt_d + (PW+1)'(spec_free_d[p]);
  end

  // State registers with asynchronous reset to the identity mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_map_q  <= MAP_RST;
      ret_map_q   <= MAP_RST;
      spec_free_q <= FREE_RST;
      ret_free_q  <= FREE_RST;
      free_cnt_q  <= (PW+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      spec_map_q  <= spec_map_d;
      ret_map_q   <= ret_map_d;
      spec_free_q <= spec_free_d;
      ret_free_q  <= ret_free_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  a_no_double_free: assert property (@(posedge clk) disable iff (!rst_n) !double_free);
`ifndef RENAME_BYPASS_EN
  a_no_group_dep: assert property (@(posedge clk) disable iff (!rst_n) !(fire && group_dep));
`endif

endmodule
`default_nettype wire
